// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive front end.
// Oversampled bit recovery (3-sample majority vote), frame FSM and LSB-first
// deserializer, feeding an external parity checker and reporting each frame
// with a one-cycle data_valid / par_err_flg / stp_err pulse.
// Optional feature: define UART_RX_BREAK_DET_EN to add the brk_det output and
// a BREAK state that absorbs a held-low line after an all-zero frame.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  par_chck_en,
  output logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err_flg,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  brk_det,
`endif
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESC_W-1:0] P_ONE    = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] P_TWO    = PRESC_W'(2);
  localparam logic [BCW-1:0]     B_ONE    = BCW'(1);
  localparam logic [BCW-1:0]     LAST_BIT = BCW'(DATA_WIDTH - 1);

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    par_en_q, par_en_d;
  logic [PRESC_W-1:0]      edge_q, edge_d;
  logic [BCW-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [2:0]              smp_q, smp_d;
  logic                    sbit_q, sbit_d;
  logic                    perr_q, perr_d;
  logic                    dv_q, dv_d;
  logic                    pef_q, pef_d;
  logic                    se_q, se_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                    brk_q, brk_d;
`endif

  logic [PRESC_W-1:0]      half;
  logic                    eob;
  logic                    maj;
  logic                    counting;

  assign half = presc_q >> 1;
  assign eob  = (edge_q == (presc_q - P_ONE));
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

`ifdef UART_RX_BREAK_DET_EN
  assign counting = (state_q != S_IDLE) && (state_q != S_BREAK);
`else
  assign counting = (state_q != S_IDLE);
`endif

  // State and datapath registers; reset clears everything including P_DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      par_en_q <= 1'b0;
      edge_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      smp_q    <= '0;
      sbit_q   <= 1'b0;
      perr_q   <= 1'b0;
      dv_q     <= 1'b0;
      pef_q    <= 1'b0;
      se_q     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      par_en_q <= par_en_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      smp_q    <= smp_d;
      sbit_q   <= sbit_d;
      perr_q   <= perr_d;
      dv_q     <= dv_d;
      pef_q    <= pef_d;
      se_q     <= se_d;
`ifdef UART_RX_BREAK_DET_EN
      brk_q    <= brk_d;
`endif
    end
  end

  // Bit timing, majority sampling, frame sequencing and result pulses.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    par_en_d = par_en_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    data_d   = data_q;
    smp_d    = smp_q;
    sbit_d   = sbit_q;
    perr_d   = perr_q;
    dv_d     = 1'b0;
    pef_d    = 1'b0;
    se_d     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_d    = 1'b0;
`endif

    // Three samples around mid-bit, vote registered one cycle later so the
    // value is settled well before the end-of-bit decision uses it.
    if (counting) begin
      edge_d = eob ? '0 : (edge_q + P_ONE);
      if (edge_q == (half - P_ONE)) smp_d[0] = RX_IN;
      if (edge_q == half)           smp_d[1] = RX_IN;
      if (edge_q == (half + P_ONE)) smp_d[2] = RX_IN;
      if (edge_q == (half + P_TWO)) sbit_d   = maj;
    end

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d  = S_START;
          presc_d  = Prescale;
          par_en_d = PAR_EN;
          edge_d   = '0;
        end
      end

      S_START: begin
        perr_d = 1'b0;
        if (eob) begin
          if (sbit_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end

      S_DATA: begin
        if (eob) begin
          data_d = {sbit_q, data_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + B_ONE;
          end
        end
      end

      S_PARITY: begin
        if (eob) begin
          perr_d  = par_err;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (eob) begin
          // A low line here is already the next start bit: relatch the
          // frame settings exactly as the IDLE path would.
          if (RX_IN) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_START;
            presc_d  = Prescale;
            par_en_d = PAR_EN;
          end
          if (!sbit_q) begin
`ifdef UART_RX_BREAK_DET_EN
            if (data_q == '0) begin
              brk_d   = 1'b1;
              state_d = S_BREAK;
            end else begin
              se_d = 1'b1;
            end
`else
            se_d = 1'b1;
`endif
          end else if (perr_q) begin
            pef_d = 1'b1;
          end else begin
            dv_d = 1'b1;
          end
        end
      end

`ifdef UART_RX_BREAK_DET_EN
      S_BREAK: begin
        if (RX_IN) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign par_chck_en = (state_q == S_PARITY);
  assign sampled_bit = sbit_q;
  assign P_DATA      = data_q;
  assign data_valid  = dv_q;
  assign par_err_flg = pef_q;
  assign stp_err     = se_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk_det     = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: serial frames are generated from the frame
// format, an even-parity checker stands in for parity_check, and every
// result pulse is compared against the outcome and timing implied by the
// frame rules.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int W  = 8;
  localparam int PW = 6;

  localparam int K_DV  = 0;
  localparam int K_PEF = 1;
  localparam int K_SE  = 2;
  localparam int K_BRK = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          par_err;
  logic          par_chck_en;
  logic          sampled_bit;
  logic [W-1:0]  P_DATA;
  logic          data_valid;
  logic          par_err_flg;
  logic          stp_err;
`ifdef UART_RX_BREAK_DET_EN
  logic          brk_det;
`endif

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          pchk_cnt = 0;

  typedef struct {
    int          kind;
    int unsigned cyc;
    logic [7:0]  data;
  } ev_t;

  ev_t ev_q[$];
  ev_t mon_ev;

  uart_rx_ctrl #(
    .DATA_WIDTH (W),
    .PRESC_W    (PW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .par_err     (par_err),
    .par_chck_en (par_chck_en),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err_flg (par_err_flg),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det     (brk_det),
`endif
    .stp_err     (stp_err)
  );

  // Even-parity checker standing in for the downstream parity_check block.
  assign par_err = par_chck_en & (sampled_bit != (^P_DATA));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every result pulse with the cycle it was seen in.
  always @(negedge CLK) begin
    mon_ev.cyc  = cyc;
    mon_ev.data = P_DATA;
    if (data_valid)  begin mon_ev.kind = K_DV;  ev_q.push_back(mon_ev); end
    if (par_err_flg) begin mon_ev.kind = K_PEF; ev_q.push_back(mon_ev); end
    if (stp_err)     begin mon_ev.kind = K_SE;  ev_q.push_back(mon_ev); end
`ifdef UART_RX_BREAK_DET_EN
    if (brk_det)     begin mon_ev.kind = K_BRK; ev_q.push_back(mon_ev); end
`endif
    if (par_chck_en) pchk_cnt = pchk_cnt + 1;
  end

  // Outcome of one frame from the frame rules.
  function automatic int model_kind(input logic [7:0] d, input logic pen,
                                    input logic pflip, input logic stop);
    if (!stop) begin
`ifdef UART_RX_BREAK_DET_EN
      if (d == 8'h00) return K_BRK;
`endif
      return K_SE;
    end
    if (pen && pflip) return K_PEF;
    return K_DV;
  endfunction

  function automatic int unsigned frame_len(input int p, input logic pen);
    return (pen ? 11 : 10) * p;
  endfunction

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // Serial frame generator; scramble changes Prescale/PAR_EN after the start.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic pflip, input logic stop, input logic scramble);
    Prescale = PW'(p);
    PAR_EN   = pen;
    RX_IN    = 1'b0;
    @(negedge CLK);
    if (scramble) begin
      Prescale = PW'((p == 8) ? 32 : 8);
      PAR_EN   = ~pen;
    end
    repeat (p - 1) @(negedge CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit((^d) ^ pflip, p);
    drive_bit(stop, p);
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({par_chck_en, sampled_bit, data_valid, par_err_flg, stp_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {par_chck_en, sampled_bit, data_valid, par_err_flg, stp_err});
    end
    checks++;
    if (P_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_pdata: got %h expected 00", P_DATA);
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input int p,
                            input logic pen, input logic pflip, input logic stop,
                            input logic scramble);
    int          n0;
    int          pc0;
    int          k;
    int unsigned c0;
    int unsigned exp_cyc;
    n0  = ev_q.size();
    pc0 = pchk_cnt;
    c0  = cyc;
    send_frame(d, p, pen, pflip, stop, scramble);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    k       = model_kind(d, pen, pflip, stop);
    exp_cyc = c0 + frame_len(p, pen) + 1;
    checks++;
    if (ev_q.size() - n0 != 1) begin
      failures++;
      $display("FAIL %s pulse_count: got %0d expected 1", name, ev_q.size() - n0);
    end else begin
      checks++;
      if (ev_q[n0].kind != k) begin
        failures++;
        $display("FAIL %s pulse_kind: got %0d expected %0d", name, ev_q[n0].kind, k);
      end
      checks++;
      if (ev_q[n0].cyc != exp_cyc) begin
        failures++;
        $display("FAIL %s pulse_cycle: got %0d expected %0d", name, ev_q[n0].cyc, exp_cyc);
      end
      if (k == K_DV) begin
        checks++;
        if (ev_q[n0].data !== d) begin
          failures++;
          $display("FAIL %s p_data: got %h expected %h", name, ev_q[n0].data, d);
        end
      end
    end
    checks++;
    if (pchk_cnt - pc0 != (pen ? p : 0)) begin
      failures++;
      $display("FAIL %s par_chck_en_cycles: got %0d expected %0d", name,
               pchk_cnt - pc0, pen ? p : 0);
    end
  endtask

  task automatic test_glitch();
    int n0;
    int pc0;
    n0       = ev_q.size();
    pc0      = pchk_cnt;
    Prescale = PW'(8);
    PAR_EN   = 1'b1;
    RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (24) @(negedge CLK);
    checks++;
    if (ev_q.size() - n0 != 0 || pchk_cnt != pc0) begin
      failures++;
      $display("FAIL glitch_no_pulses: got %0d pulses %0d parity cycles expected 0 0",
               ev_q.size() - n0, pchk_cnt - pc0);
    end
    test_frame("after_glitch", 8'h96, 8, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int          n0;
    int unsigned c0;
    n0 = ev_q.size();
    c0 = cyc;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (ev_q.size() - n0 != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 2", ev_q.size() - n0);
    end else begin
      checks++;
      if (ev_q[n0].kind != K_DV || ev_q[n0].data !== 8'h12) begin
        failures++;
        $display("FAIL b2b_first: got kind %0d data %h expected kind 0 data 12",
                 ev_q[n0].kind, ev_q[n0].data);
      end
      checks++;
      if (ev_q[n0+1].kind != K_DV || ev_q[n0+1].data !== 8'h34) begin
        failures++;
        $display("FAIL b2b_second: got kind %0d data %h expected kind 0 data 34",
                 ev_q[n0+1].kind, ev_q[n0+1].data);
      end
      checks++;
      if (ev_q[n0].cyc != c0 + 81) begin
        failures++;
        $display("FAIL b2b_first_cycle: got %0d expected %0d", ev_q[n0].cyc, c0 + 81);
      end
      checks++;
      if (ev_q[n0+1].cyc - ev_q[n0].cyc != 80) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d expected 80", ev_q[n0+1].cyc - ev_q[n0].cyc);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int         n0;
    logic [7:0] d;
    d        = 8'hC3;
    n0       = ev_q.size();
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    RX_IN = d[4];
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({par_chck_en, sampled_bit, data_valid, par_err_flg, stp_err} !== 5'b0 ||
        P_DATA !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset_outputs: got flags %b data %h expected 00000 00",
               {par_chck_en, sampled_bit, data_valid, par_err_flg, stp_err}, P_DATA);
    end
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (ev_q.size() - n0 != 0) begin
      failures++;
      $display("FAIL midframe_reset_no_pulse: got %0d expected 0", ev_q.size() - n0);
    end
    test_frame("after_reset_55", 8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int         p;
    logic [7:0] d;
    logic       pen, pflip, stop, scr;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d     = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pen   = 1'($urandom_range(0, 1));
      pflip = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 4) != 0);
      scr   = 1'($urandom_range(0, 1));
      test_frame($sformatf("rand%0d", i), d, p, pen, pflip, stop, scr);
    end
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    @(negedge CLK);
    test_reset();
    test_frame("a5_parity_ok", 8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    test_frame("3c_parity_bad", 8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    test_glitch();
    test_frame("81_stop_zero", 8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_midframe();
    test_frame("zero_stop_zero", 8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    test_frame("scrambled_cfg", 8'h6E, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
